// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : MCU data-memory access controller (IDLE/SETUP/ACCESS/DONE).
//               Optional access timeout enabled by macro DMEM_CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic              addr_sel,
   input  logic [ADDR_W-1:0] addr_imm,
   input  logic [ADDR_W-1:0] addr_reg,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_cs,
   output logic              mem_we,
   input  logic              mem_rdy,
   inout  wire  [DATA_W-1:0] mem_data
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_chk
      $error("dmem_ctrl: TIMEOUT_CYCLES must be within 1..255");
   end

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef DMEM_CTRL_TIMEOUT_EN
   logic [7:0]          cnt_q, cnt_d;
   logic [7:0]          cnt_inc;
   logic                err_q, err_d;

   assign cnt_inc = cnt_q + 8'd1;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef DMEM_CTRL_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = addr_sel ? addr_reg : addr_imm;
               we_d    = we;
               wdata_d = wdata;
               state_d = S_SETUP;
`ifdef DMEM_CTRL_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
`ifdef DMEM_CTRL_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
         end
         S_ACCESS: begin
            if (mem_rdy) begin
               state_d = S_DONE;
               if (!we_q) begin
                  rdata_d = mem_data;
               end
`ifdef DMEM_CTRL_TIMEOUT_EN
               err_d   = 1'b0;
            end else begin
               // The cycle in which the count reaches the limit aborts the access.
               cnt_d = cnt_inc;
               if (cnt_inc == 8'(TIMEOUT_CYCLES)) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef DMEM_CTRL_TIMEOUT_EN
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef DMEM_CTRL_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign busy     = (state_q == S_SETUP) || (state_q == S_ACCESS);
   assign mem_cs   = busy;
   assign mem_we   = (state_q == S_ACCESS) && we_q;
   assign done     = (state_q == S_DONE);
   assign mem_addr = addr_q;
   assign rdata    = rdata_q;
   assign mem_data = (busy && we_q) ? wdata_q : {DATA_W{1'bz}};

`ifdef DMEM_CTRL_TIMEOUT_EN
   assign err = done && err_q;
`else
   assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Scoreboard bench for dmem_ctrl with directed access vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_ctrl;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic          we = 1'b0;
   logic          addr_sel = 1'b0;
   logic [AW-1:0] addr_imm = '0;
   logic [AW-1:0] addr_reg = '0;
   logic [DW-1:0] wdata = '0;
   wire  [DW-1:0] rdata;
   wire           busy, done, err, mem_cs, mem_we;
   wire  [AW-1:0] mem_addr;
   logic          mem_rdy = 1'b0;
   wire  [DW-1:0] mem_data;
   logic          tb_drv = 1'b0;
   logic [DW-1:0] tb_val = '0;

   assign mem_data = tb_drv ? tb_val : {DW{1'bz}};

   dmem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr_sel(addr_sel),
      .addr_imm(addr_imm), .addr_reg(addr_reg), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .err(err),
      .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we),
      .mem_rdy(mem_rdy), .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      logic [DW-1:0] rdata;
      logic          err;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t          sb_q[$];
   int            checks = 0;
   int            failures = 0;
   logic [DW-1:0] model_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Completion monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            e = sb_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
            chk("err", {31'd0, err}, {31'd0, e.err});
            chk("mem_addr", {24'd0, mem_addr}, {24'd0, e.addr});
         end
      end
   end

   // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
   task automatic access(input logic sel, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] rv,
                         input int waits, input logic hold);
      int   n_acc;
      logic e_err;
      exp_t e;
      n_acc = waits + 1;
      e_err = 1'b0;
`ifdef DMEM_CTRL_TIMEOUT_EN
      if (waits >= TO) begin
         n_acc = TO;
         e_err = 1'b1;
      end
`endif
      if (!w && !e_err) model_rdata = rv;
      e.cyc   = cyc + 3 + (n_acc - 1);
      e.rdata = model_rdata;
      e.err   = e_err;
      e.addr  = a;
      sb_q.push_back(e);

      req      = 1'b1;
      we       = w;
      addr_sel = sel;
      addr_imm = sel ? ~a : a;
      addr_reg = sel ? a : ~a;
      wdata    = d;
      @(posedge clk);
      @(negedge clk);
      if (!hold) req = 1'b0;
      we    = ~w;
      wdata = ~d;
      chk("setup_busy", {31'd0, busy}, 32'd1);
      chk("setup_cs", {31'd0, mem_cs}, 32'd1);
      chk("setup_we", {31'd0, mem_we}, 32'd0);
      chk("setup_addr", {24'd0, mem_addr}, {24'd0, a});
      if (w) chk("setup_bus", {24'd0, mem_data}, {24'd0, d});
      for (int k = 1; k <= n_acc; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("access_cs", {31'd0, mem_cs}, 32'd1);
         chk("access_we", {31'd0, mem_we}, {31'd0, w});
         if (w) chk("access_bus", {24'd0, mem_data}, {24'd0, d});
         else begin
            tb_val = rv;
            tb_drv = 1'b1;
         end
         mem_rdy = (k > waits);
      end
      @(posedge clk);
      @(negedge clk);
      tb_drv  = 1'b0;
      mem_rdy = 1'b0;
      chk("done_busy", {31'd0, busy}, 32'd0);
      chk("done_cs", {31'd0, mem_cs}, 32'd0);
      chk("done_we", {31'd0, mem_we}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      if (w && !hold) begin
         tb_val = 8'h33;
         tb_drv = 1'b1;
         #1;
         chk("bus_released", {24'd0, mem_data}, 32'h33);
         tb_drv = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_cs", {31'd0, mem_cs}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_rdata", {24'd0, rdata}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);

      access(1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5, 0, 1'b0);
      access(1'b1, 1'b1, 8'h81, 8'h5A, 8'h00, 2, 1'b0);
      access(1'b1, 1'b0, 8'h10, 8'h00, 8'h3E, 1, 1'b0);
`ifdef DMEM_CTRL_TIMEOUT_EN
      access(1'b0, 1'b0, 8'h20, 8'h00, 8'hEE, 10, 1'b0);
      access(1'b0, 1'b0, 8'h21, 8'h00, 8'h77, TO - 1, 1'b0);
`else
      access(1'b0, 1'b0, 8'hFF, 8'h00, 8'hC3, 20, 1'b0);
`endif

      // Reset in the middle of a write access.
      req = 1'b1; we = 1'b1; addr_sel = 1'b0; addr_imm = 8'h44; wdata = 8'h99;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rstacc_we", {31'd0, mem_we}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_rdata = '0;
      chk("rstacc_busy", {31'd0, busy}, 32'd0);
      chk("rstacc_cs", {31'd0, mem_cs}, 32'd0);
      chk("rstacc_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rstacc_rdata", {24'd0, rdata}, 32'd0);
      tb_val = 8'h5C;
      tb_drv = 1'b1;
      #1;
      chk("rstacc_bus", {24'd0, mem_data}, 32'h5C);
      tb_drv = 1'b0;
      repeat (3) @(negedge clk);

      // Back-to-back reads with req held high through DONE.
      access(1'b0, 1'b0, 8'h01, 8'h00, 8'h11, 0, 1'b1);
      access(1'b1, 1'b0, 8'h02, 8'h00, 8'h22, 0, 1'b1);
      access(1'b0, 1'b0, 8'h03, 8'h00, 8'h33, 0, 1'b1);
      req = 1'b0;

      repeat (5) @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_rdata", {24'd0, rdata}, {24'd0, model_rdata});
      chk("pending_done", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, data memory address width in bits.
REQ-002 Parameter DATA_W, default 8, data word width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-state cycles before abort; valid range 1..255.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset:
  clk  in  1  clock; all state updates on rising edge.
  rst  in  1  synchronous active-high reset.
REQ-005 MCU-side ports SHALL be:
  req       in   1       access request, sampled in IDLE only.
  we        in   1       1 = write, 0 = read; sampled with req.
  addr_sel  in   1       0 = immediate address, 1 = register-indirect address.
  addr_imm  in   ADDR_W  direct-mode address.
  addr_reg  in   ADDR_W  register-indirect address.
  wdata     in   DATA_W  write data, sampled with req.
  rdata     out  DATA_W  last successfully read word.
  busy      out  1       high in SETUP and ACCESS.
  done      out  1       one-cycle completion pulse.
  err       out  1       timeout flag, valid only while done = 1.
REQ-006 Memory-side ports SHALL be:
  mem_addr  out    ADDR_W  registered address.
  mem_cs    out    1       chip select.
  mem_we    out    1       write strobe.
  mem_rdy   in     1       memory ready.
  mem_data  inout  DATA_W  bidirectional data bus.

Function
REQ-007 The FSM SHALL have exactly four states: IDLE, SETUP, ACCESS and DONE.
REQ-008 In IDLE with req = 1, the block SHALL latch addr_imm or addr_reg (selected by addr_sel) into mem_addr, and SHALL latch we and wdata; next state SETUP. With req = 0 it SHALL stay in IDLE.
REQ-009 SETUP SHALL last exactly one cycle with mem_cs = 1 and mem_we = 0; next state ACCESS.
REQ-010 In ACCESS, mem_cs = 1 and mem_we = latched we. When mem_rdy = 1, the next state SHALL be DONE and, on a read, rdata SHALL capture mem_data on that same edge.
REQ-011 DONE SHALL last one cycle with done = 1, mem_cs = 0 and mem_we = 0; next state IDLE. req SHALL be ignored while in DONE.
REQ-012 mem_data SHALL be driven with the latched wdata only in SETUP and ACCESS of a write; otherwise it SHALL be all high impedance.
REQ-013 Minimum latency: req sampled at edge N gives done = 1 in cycle N+3 when mem_rdy = 1 on the first ACCESS cycle. Each additional mem_rdy = 0 cycle in ACCESS adds one cycle.
REQ-014 rdata SHALL keep its value across writes, timed-out accesses and idle cycles.
REQ-015 busy SHALL equal 1 exactly in SETUP and ACCESS.
REQ-016 mem_addr SHALL hold its last latched value outside IDLE-to-SETUP transitions.
REQ-017 Back-to-back accesses: req held high SHALL start a new access on the first IDLE cycle after DONE (one access per 4 cycles minimum).

Reset
REQ-018 On rst = 1 at a rising edge, the block SHALL enter IDLE, clear rdata, mem_addr, mem_cs, mem_we, busy, done, err and the timeout counter, and release mem_data to high impedance.
REQ-019 rst asserted during SETUP, ACCESS or DONE SHALL abandon the access with no done pulse and no rdata update; rst SHALL override all other inputs.

Configuration
REQ-020 With macro DMEM_CTRL_TIMEOUT_EN defined, a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with mem_rdy = 0. On reaching TIMEOUT_CYCLES, the FSM SHALL go to DONE with err = 1 and rdata unchanged.
REQ-021 mem_rdy = 1 in the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete normally with err = 0.
REQ-022 Without DMEM_CTRL_TIMEOUT_EN, ACCESS SHALL wait indefinitely, err SHALL be constant 0, and no counter logic SHALL be present.

Verification
REQ-023 Read, addr_sel = 0, addr_imm = 0x3C, memory returns 0xA5 with rdy on the first ACCESS cycle -> mem_addr = 0x3C, done at N+3, rdata = 0xA5, err = 0.
REQ-024 Write, addr_sel = 1, addr_reg = 0x81, wdata = 0x5A, rdy after 2 wait cycles -> mem_data = 0x5A during SETUP/ACCESS, mem_we = 1 in ACCESS, done at N+5, bus Z afterwards, rdata unchanged.
REQ-025 With DMEM_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES = 4, read with mem_rdy held 0 -> done and err = 1 after 4 ACCESS cycles, rdata keeps its previous value; repeat with rdy = 1 on the 4th cycle -> err = 0.
REQ-026 rst pulsed during ACCESS of a write -> next cycle IDLE, mem_cs = 0, bus Z, no done pulse.
REQ-027 req held high for 3 reads -> three done pulses spaced 4 cycles apart, and req is ignored in DONE.
